// File: rtl/pe_control_sequencer.sv
// Global PE local-store command sequencer: per-PE offset programming, INIT, then a rows x cols walk.
// Optional busy-cycle counter output enabled by PE_SEQ_CYCLE_CNT_EN.
module pe_control_sequencer #(
   parameter int depth = 2,
   parameter int D     = 1 << depth,
   parameter int NPE   = D * D,
   parameter int A     = 7
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [A-1:0]     num_rows,
   input  logic [A-1:0]     num_cols,
   input  logic             stall,
   output logic [5:0]       controlSignal,
   output logic [NPE-1:0]   initPESelect,
   output logic [depth-1:0] initSettings,
   output logic             mac_valid,
   output logic             mac_last,
   output logic             busy,
`ifdef PE_SEQ_CYCLE_CNT_EN
   output logic             done,
   output logic [15:0]      busy_cycles
`else
   output logic             done
`endif
);

   localparam int PW = 2 * depth;

   localparam logic [2:0] C_INIT = 3'b000;
   localparam logic [2:0] C_HOLD = 3'b001;
   localparam logic [2:0] C_INCR = 3'b010;
   localparam logic [2:0] C_JUMP = 3'b011;
   localparam logic [5:0] W_IDLE = {C_HOLD, C_HOLD};
   localparam logic [5:0] W_ROW  = {3'b100, 3'b110};
   localparam logic [5:0] W_COL  = {3'b101, 3'b111};

   typedef enum logic [2:0] {s_idle, s_cfg, s_init, s_run, s_done} state_t;

   state_t         state, state_n;
   logic [PW-1:0]  p, p_n;
   logic           ph, ph_n;
   logic [A-1:0]   r, r_n, c, c_n, rows_q, rows_n, cols_q, cols_n;
   logic [A-1:0]   rr, cc, rmax, cmax;
   logic           step;
   logic [5:0]     ctrl_n;
   logic [NPE-1:0] sel_n;
   logic [depth-1:0] set_n;
   logic           valid_n, last_n, busy_n, done_n;

   assign rmax = rows_q - A'(1);
   assign cmax = cols_q - A'(1);

   // Every output register is loaded with the word for the cycle that the next state represents.
   always_comb begin
      state_n = state;
      p_n     = p;
      ph_n    = ph;
      r_n     = r;
      c_n     = c;
      rows_n  = rows_q;
      cols_n  = cols_q;
      ctrl_n  = W_IDLE;
      sel_n   = '0;
      set_n   = '0;
      valid_n = 1'b0;
      last_n  = 1'b0;
      busy_n  = 1'b1;
      done_n  = 1'b0;
      step    = 1'b0;
      rr      = r;
      cc      = c;
      case (state)
         s_idle: begin
            busy_n = 1'b0;
            if (start) begin
               rows_n  = num_rows;
               cols_n  = num_cols;
               p_n     = '0;
               ph_n    = 1'b0;
               state_n = s_cfg;
               busy_n  = 1'b1;
            end
         end
         s_cfg: begin
            if (!ph) begin
               ph_n = 1'b1;
            end else if (p == PW'(NPE - 1)) begin
               state_n = s_init;
               ctrl_n  = {C_INIT, C_INIT};
            end else begin
               p_n  = p + PW'(1);
               ph_n = 1'b0;
            end
         end
         s_init: begin
            if (rows_q == '0 || cols_q == '0) begin
               state_n = s_done;
               done_n  = 1'b1;
            end else begin
               state_n = s_run;
               rr      = '0;
               cc      = '0;
               step    = 1'b1;
            end
         end
         s_run: begin
            // mac_last marks that the final element was just issued
            if (mac_last) begin
               state_n = s_done;
               done_n  = 1'b1;
            end else begin
               step = 1'b1;
            end
         end
         s_done: begin
            state_n = s_idle;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = s_idle;
            busy_n  = 1'b0;
         end
      endcase

      if (step) begin
         r_n = rr;
         c_n = cc;
         if (!stall) begin
            valid_n = 1'b1;
            if (cc != cmax) begin
               ctrl_n = {C_INCR, C_INCR};
               c_n    = cc + A'(1);
            end else if (rr != rmax) begin
               ctrl_n = {C_JUMP, C_JUMP};
               c_n    = '0;
               r_n    = rr + A'(1);
            end else begin
               last_n = 1'b1;
            end
         end
      end

      if (state_n == s_cfg) begin
         ctrl_n = ph_n ? W_COL : W_ROW;
         sel_n  = NPE'(1) << p_n;
         set_n  = ph_n ? depth'(p_n & PW'(D - 1)) : depth'(p_n >> depth);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= s_idle;
         p             <= '0;
         ph            <= 1'b0;
         r             <= '0;
         c             <= '0;
         rows_q        <= '0;
         cols_q        <= '0;
         controlSignal <= W_IDLE;
         initPESelect  <= '0;
         initSettings  <= '0;
         mac_valid     <= 1'b0;
         mac_last      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_n;
         p             <= p_n;
         ph            <= ph_n;
         r             <= r_n;
         c             <= c_n;
         rows_q        <= rows_n;
         cols_q        <= cols_n;
         controlSignal <= ctrl_n;
         initPESelect  <= sel_n;
         initSettings  <= set_n;
         mac_valid     <= valid_n;
         mac_last      <= last_n;
         busy          <= busy_n;
         done          <= done_n;
      end
   end

`ifdef PE_SEQ_CYCLE_CNT_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         busy_cycles <= '0;
      else if (state == s_idle && start)
         busy_cycles <= '0;
      else if (busy && busy_cycles != 16'hFFFF)
         busy_cycles <= busy_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pe_control_sequencer.sv
// Randomized self-checking bench for pe_control_sequencer against a tile-level command list model.
module tb_pe_control_sequencer;
   localparam int DEP = 2;
   localparam int N   = 16;
   localparam int A   = 7;
   localparam logic [5:0] IDLEW = 6'b001001;

   logic           CLK, RST, start, stall;
   logic [A-1:0]   num_rows, num_cols;
   logic [5:0]     controlSignal;
   logic [N-1:0]   initPESelect;
   logic [DEP-1:0] initSettings;
   logic           mac_valid, mac_last, busy, done;
`ifdef PE_SEQ_CYCLE_CNT_EN
   logic [15:0]    busy_cycles;
`endif

   int total = 0, bad = 0;

   pe_control_sequencer #(.depth(DEP), .A(A)) dut (
      .CLK(CLK), .RST(RST), .start(start), .num_rows(num_rows), .num_cols(num_cols),
      .stall(stall), .controlSignal(controlSignal), .initPESelect(initPESelect),
      .initSettings(initSettings), .mac_valid(mac_valid), .mac_last(mac_last),
`ifdef PE_SEQ_CYCLE_CNT_EN
      .busy(busy), .done(done), .busy_cycles(busy_cycles)
`else
      .busy(busy), .done(done)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_idle_outs(input string tag, input bit exp_busy, input bit exp_done);
      chk({tag, ".ctrl"}, 32'(controlSignal), 32'(IDLEW));
      chk({tag, ".sel"}, 32'(initPESelect), 0);
      chk({tag, ".valid"}, 32'(mac_valid), 0);
      chk({tag, ".last"}, 32'(mac_last), 0);
      chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, ".done"}, 32'(done), 32'(exp_done));
   endtask

   function automatic bit pick_stall(input int smode, input int rc);
      case (smode)
         1: return ($urandom_range(0, 3) == 0);
         2: return (rc == 1 || rc == 3);
         default: return 1'b0;
      endcase
   endfunction

   // smode: 0 none, 1 random, 2 stall on 2nd/4th RUN cycle. abort_at>0 resets after that many valids.
   task automatic run_tile(input int rows, input int cols, input int smode, input bit inj, input int abort_at);
      logic [5:0] q[$];
      logic [5:0] w;
      logic [2:0] k;
      int stalls = 0, nval = 0, rc = 0, cyc = 0;
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) begin
            k = (c < cols - 1) ? 3'b010 : (r < rows - 1) ? 3'b011 : 3'b001;
            q.push_back({k, k});
         end
      num_rows = A'(rows);
      num_cols = A'(cols);
      start = 1'b1;
      tick(); cyc++;
      num_rows = A'($urandom_range(1, 9));
      num_cols = A'($urandom_range(1, 9));
      for (int p = 0; p < N; p++)
         for (int ph = 0; ph < 2; ph++) begin
            chk("cfg.ctrl", 32'(controlSignal), ph ? 32'h2f : 32'h26);
            chk("cfg.sel", 32'(initPESelect), 32'(1) << p);
            chk("cfg.set", 32'(initSettings), ph ? 32'(p % 4) : 32'(p / 4));
            chk("cfg.busy", 32'(busy), 1);
            chk("cfg.valid", 32'(mac_valid), 0);
            start = inj && p == 3 && ph == 0;
            tick(); cyc++;
         end
      chk("init.ctrl", 32'(controlSignal), 0);
      chk("init.sel", 32'(initPESelect), 0);
      chk("init.valid", 32'(mac_valid), 0);
      chk("init.busy", 32'(busy), 1);
      stall = pick_stall(smode, rc);
      tick(); cyc++;
      while (q.size() > 0) begin
         if (stall) begin
            stalls++;
            chk("run.stall.ctrl", 32'(controlSignal), 32'(IDLEW));
            chk("run.stall.valid", 32'(mac_valid), 0);
            chk("run.stall.last", 32'(mac_last), 0);
         end else begin
            w = q.pop_front();
            nval++;
            chk("run.ctrl", 32'(controlSignal), 32'(w));
            chk("run.valid", 32'(mac_valid), 1);
            chk("run.last", 32'(mac_last), 32'(q.size() == 0));
            chk("run.done", 32'(done), 0);
            if (abort_at > 0 && nval == abort_at) begin
               RST = 1'b1;
               #1;
               chk_idle_outs("abort", 0, 0);
`ifdef PE_SEQ_CYCLE_CNT_EN
               chk("abort.cnt", 32'(busy_cycles), 0);
`endif
               stall = 1'b0;
               start = 1'b0;
               @(negedge CLK);
               RST = 1'b0;
               tick();
               chk_idle_outs("abort.after", 0, 0);
               return;
            end
         end
         rc++;
         stall = pick_stall(smode, rc);
         start = inj && rc == 2;
         tick(); cyc++;
      end
      chk_idle_outs("done", 1, 1);
      chk("latency", 32'(cyc), 32'(2 * N + 2 + rows * cols + stalls));
      start = 1'b1;
      stall = 1'b0;
      tick();
      start = 1'b0;
      chk_idle_outs("post", 0, 0);
`ifdef PE_SEQ_CYCLE_CNT_EN
      chk("cnt.after", 32'(busy_cycles), 32'(2 * N + 2 + rows * cols + stalls));
      tick();
      chk("cnt.hold", 32'(busy_cycles), 32'(2 * N + 2 + rows * cols + stalls));
      chk("cnt.hold.busy", 32'(busy), 0);
`endif
   endtask

   initial begin
      RST = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      num_rows = '0;
      num_cols = '0;
      tick();
      chk_idle_outs("reset", 0, 0);
      chk("reset.set", 32'(initSettings), 0);
`ifdef PE_SEQ_CYCLE_CNT_EN
      chk("reset.cnt", 32'(busy_cycles), 0);
`endif
      @(negedge CLK);
      RST = 1'b0;
      tick();
      chk_idle_outs("idle", 0, 0);

      run_tile(2, 3, 0, 1'b0, 0);
      run_tile(2, 3, 2, 1'b0, 0);
      run_tile(0, 5, 1, 1'b0, 0);
      run_tile(3, 4, 0, 1'b1, 0);
      run_tile(4, 4, 0, 1'b0, 3);
      run_tile(4, 4, 1, 1'b0, 0);
      run_tile(1, 1, 1, 1'b0, 0);
      run_tile(5, 0, 0, 1'b0, 0);
      for (int i = 0; i < 6; i++)
         run_tile($urandom_range(0, 5), $urandom_range(0, 5), 1, 1'($urandom_range(0, 1)), 0);
`ifdef PE_SEQ_CYCLE_CNT_EN
      num_rows = A'(1);
      num_cols = A'(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cnt.clear", 32'(busy_cycles), 0);
      repeat (2 * N + 3) tick();
      chk("cnt.final", 32'(busy_cycles), 32'(2 * N + 3));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
